// File: rtl/adc_buff_pkg.sv
// Shared types and defaults for the adc_buff serial ADC capture buffer.
// Optional ping-pong buffering is enabled by defining ADC_BUFF_TOGGLE_EN.
package adc_buff_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CS_SETUP,
        SHIFT,
        STORE_HI,
        STORE_LO
    } state_t;

    localparam int SCLK_HALF_DEF   = 8;
    localparam int CS_SETUP_DEF    = 2;
    localparam int NUM_SAMPLES_DEF = 128;
    localparam int WORD_W          = 16;
    localparam int BYTE_W          = 8;

    // Terminal count of the decimation counter: 2^rate - 1.
    function automatic logic [6:0] decim_mask(input logic [2:0] rate);
        return 7'((8'd1 << rate) - 8'd1);
    endfunction

endpackage

// File: rtl/adc_buff_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Contents are not reset.
module adc_buff_ram
    import adc_buff_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = BYTE_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port plus registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/adc_buff.sv
// Serial ADC capture buffer: waits for nDRDY falls, reads 16-bit words MSB
// first over nCS1/SCLK1/SDIN1, keeps one conversion in 2^rate and stores each
// kept word as two bytes (high byte first) in RAM.
// Define ADC_BUFF_TOGGLE_EN for a 512-byte ping-pong buffer with toggle_buff.
module adc_buff
    import adc_buff_pkg::*;
#(
    parameter int SCLK_HALF   = SCLK_HALF_DEF,
    parameter int CS_SETUP    = CS_SETUP_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_pulse,
    input  logic [2:0] rate,
    output logic       write_done,
    input  logic [7:0] read_addr,
    output logic [7:0] dout,
    input  logic       nDRDY,
    input  logic       SDIN1,
    output logic       SCLK1,
    output logic       nCS1
`ifdef ADC_BUFF_TOGGLE_EN
    ,
    output logic       toggle_buff
`endif
);

    localparam int PTR_W = $clog2(NUM_SAMPLES);
    localparam int TMR_W = 8;
    localparam int BIT_W = $clog2(WORD_W);

    state_t             state_q, state_d;
    logic [1:0]         drdy_s;
    logic [1:0]         sdin_s;
    logic               drdy_fall;
    logic [2:0]         rate_q;
    logic [6:0]         decim_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [BIT_W-1:0]   bit_q;
    logic               sclk_q;
    logic [WORD_W-1:0]  word_q;
    logic               half_end;
    logic               last_sample;
    logic               ram_we;
    logic               byte_sel;
    logic [BYTE_W-1:0]  ram_wdata;
    logic               toggle_q;

    assign drdy_fall   = drdy_s[1] & ~drdy_s[0];
    assign half_end    = (tmr_q == TMR_W'(SCLK_HALF - 1));
    assign last_sample = (ptr_q == PTR_W'(NUM_SAMPLES - 1));
    assign SCLK1       = sclk_q;

    // Synchronizers for the asynchronous ADC inputs; idle-high nDRDY avoids a false fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            drdy_s <= 2'b11;
        end else begin
            drdy_s <= {drdy_s[0], nDRDY};
        end
        sdin_s <= {sdin_s[0], SDIN1};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state outputs.
    always_comb begin
        state_d    = state_q;
        nCS1       = 1'b1;
        write_done = 1'b0;
        ram_we     = 1'b0;
        byte_sel   = 1'b0;
        ram_wdata  = word_q[15:8];
        case (state_q)
            IDLE: begin
                if (start_pulse) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (drdy_fall && decim_q == '0) begin
                    state_d = adc_buff_pkg::CS_SETUP;
                end
            end
            adc_buff_pkg::CS_SETUP: begin
                nCS1 = 1'b0;
                if (tmr_q == TMR_W'(CS_SETUP - 1)) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                nCS1 = 1'b0;
                if (half_end && sclk_q && bit_q == BIT_W'(WORD_W - 1)) begin
                    state_d = STORE_HI;
                end
            end
            STORE_HI: begin
                ram_we  = 1'b1;
                state_d = STORE_LO;
            end
            STORE_LO: begin
                ram_we    = 1'b1;
                byte_sel  = 1'b1;
                ram_wdata = word_q[7:0];
                if (last_sample) begin
                    write_done = 1'b1;
`ifdef ADC_BUFF_TOGGLE_EN
                    state_d = ARMED;
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencing counters: rate capture, decimation, CS setup/SCLK timing, sample pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q   <= '0;
            decim_q  <= '0;
            ptr_q    <= '0;
            tmr_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        rate_q  <= rate;
                        decim_q <= '0;
                        ptr_q   <= '0;
                    end
                end
                ARMED: begin
                    tmr_q  <= '0;
                    bit_q  <= '0;
                    sclk_q <= 1'b0;
                    if (drdy_fall) begin
                        decim_q <= (decim_q == decim_mask(rate_q)) ? '0 : decim_q + 7'd1;
                    end
                end
                adc_buff_pkg::CS_SETUP: begin
                    tmr_q <= (tmr_q == TMR_W'(CS_SETUP - 1)) ? '0 : tmr_q + TMR_W'(1);
                end
                SHIFT: begin
                    if (half_end) begin
                        tmr_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                STORE_LO: begin
                    if (last_sample) begin
                        ptr_q    <= '0;
                        toggle_q <= ~toggle_q;
                    end else begin
                        ptr_q <= ptr_q + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Serial word capture on the clk where SCLK1 goes 0->1 (data path, no reset).
    always_ff @(posedge clk) begin
        if (state_q == SHIFT && half_end && !sclk_q) begin
            word_q <= {word_q[WORD_W-2:0], sdin_s[1]};
        end
    end

`ifdef ADC_BUFF_TOGGLE_EN
    assign toggle_buff = toggle_q;

    adc_buff_ram #(
        .ADDR_W (9),
        .DATA_W (BYTE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({~toggle_q, 8'({ptr_q, byte_sel})}),
        .wdata (ram_wdata),
        .raddr ({toggle_q, read_addr}),
        .rdata (dout)
    );
`else
    adc_buff_ram #(
        .ADDR_W (8),
        .DATA_W (BYTE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (8'({ptr_q, byte_sel})),
        .wdata (ram_wdata),
        .raddr (read_addr),
        .rdata (dout)
    );
`endif

endmodule

// File: tb/tb_adc_buff.sv
// Bench for adc_buff: behavioural ADC model plus a record of every conversion
// it produced; expected RAM bytes are picked from that record by index.
module tb_adc_buff;

    localparam int SH  = 4;     // SCLK half period in clk
    localparam int CSU = 2;
    localparam int NS  = 128;
    localparam int P   = 150;   // ADC conversion period in clk
    localparam int HI  = 5;     // nDRDY high time in clk

    logic       clk = 1'b0;
    logic       reset, start_pulse, write_done, nDRDY, SDIN1, SCLK1, nCS1;
    logic [2:0] rate;
    logic [7:0] read_addr, dout;
`ifdef ADC_BUFF_TOGGLE_EN
    logic       toggle_buff;
`endif

    always #20 clk = ~clk;

    adc_buff #(.SCLK_HALF(SH), .CS_SETUP(CSU), .NUM_SAMPLES(NS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_pulse (start_pulse),
        .rate        (rate),
        .write_done  (write_done),
        .read_addr   (read_addr),
        .dout        (dout),
        .nDRDY       (nDRDY),
        .SDIN1       (SDIN1),
        .SCLK1       (SCLK1),
        .nCS1        (nCS1)
`ifdef ADC_BUFF_TOGGLE_EN
        ,
        .toggle_buff (toggle_buff)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- ADC model ----------------
    logic [15:0] adc_sr = 16'h0;
    logic [15:0] conv_q [$];
    logic        adc_rand    = 1'b0;
    logic        restart_req = 1'b0;
    logic        restart_ack = 1'b0;
    assign SDIN1 = adc_sr[15];

    initial begin
        int ph;
        int cnt;
        logic sclk_prev;
        logic [15:0] v;
        ph = 0; cnt = 0; sclk_prev = 1'b0;
        nDRDY = 1'b1;
        forever begin
            @(negedge clk);
            if (ph == 0) begin
                nDRDY = 1'b1;
                if (restart_req != restart_ack) begin
                    cnt = 0;
                    restart_ack = restart_req;
                end
                v = adc_rand ? 16'($urandom) : 16'(cnt);
                cnt++;
                adc_sr = v;
                conv_q.push_back(v);
            end else if (ph == HI) begin
                nDRDY = 1'b0;
            end
            if (sclk_prev && !SCLK1) adc_sr = adc_sr << 1;
            sclk_prev = SCLK1;
            ph = (ph == P - 1) ? 0 : ph + 1;
        end
    end

    // ---------------- bus monitor ----------------
    logic mon_clr = 1'b0;
    int m_reads, m_badlen, m_badrise, m_badper, m_rises_all, m_rises_idle, m_low, m_wd, m_wdwide;
    int low_len, rise_cnt, last_rise, cyc;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_wd = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_clr) begin
            m_reads = 0; m_badlen = 0; m_badrise = 0; m_badper = 0; m_rises_all = 0;
            m_rises_idle = 0; m_low = 0; m_wd = 0; m_wdwide = 0; low_len = 0; rise_cnt = 0;
        end else begin
            if (SCLK1 === 1'b1 && !prev_sclk) begin
                m_rises_all++;
                if (nCS1 !== 1'b0) m_rises_idle++;
                else begin
                    rise_cnt++;
                    if (rise_cnt > 1 && cyc - last_rise != 2 * SH) m_badper++;
                    last_rise = cyc;
                end
            end
            if (nCS1 === 1'b0) begin
                low_len++;
                m_low++;
            end
            if (nCS1 === 1'b1 && !prev_cs) begin
                m_reads++;
                if (low_len != CSU + 32 * SH) m_badlen++;
                if (rise_cnt != 16) m_badrise++;
                low_len = 0;
                rise_cnt = 0;
            end
            if (write_done === 1'b1) begin
                if (prev_wd) m_wdwide++;
                else m_wd++;
            end
        end
        prev_cs = (nCS1 !== 1'b0);
        prev_sclk = (SCLK1 === 1'b1);
        prev_wd = (write_done === 1'b1);
    end

    // ---------------- helpers ----------------
    int mark;

    function automatic logic [7:0] exp_byte(input int a, input int r, input int m);
        int idx;
        logic [15:0] s;
        idx = m + ((a / 2) << r);
        if (idx >= conv_q.size()) return 8'bx;
        s = conv_q[idx];
        return (a % 2 == 1) ? s[7:0] : s[15:8];
    endfunction

    task automatic mon_clear();
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] r, input logic rnd);
`ifdef ADC_BUFF_TOGGLE_EN
        reset = 1'b1; @(negedge clk); reset = 1'b0;
`endif
        @(negedge nDRDY);
        repeat (20) @(negedge clk);
        adc_rand = rnd;
        restart_req = ~restart_req;
        mark = conv_q.size();
        rate = r;
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        rate = 3'($urandom);
    endtask

    task automatic read_byte(input int a, output logic [7:0] d);
        @(negedge clk);
        read_addr = 8'(a);
        @(negedge clk);
        d = dout;
    endtask

    task automatic bus_checks(input string tag, input int reads);
        @(posedge clk);
        check({tag, " reads"}, m_reads, reads);
        check({tag, " cs_low_len"}, m_badlen, 0);
        check({tag, " sclk_rises"}, m_badrise, 0);
        check({tag, " sclk_period"}, m_badper, 0);
        check({tag, " sclk_idle"}, m_rises_idle, 0);
    endtask

    initial begin
        #(150000 * 40);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] d;
        logic found;
        logic tog0;
        int a;

        reset = 1'b1; start_pulse = 1'b0; rate = 3'd0; read_addr = 8'd0;
        repeat (3) @(negedge clk);
        check("reset nCS1", nCS1, 1'b1);
        check("reset SCLK1", SCLK1, 1'b0);
        check("reset write_done", write_done, 1'b0);
        reset = 1'b0;

        // Idle: ADC keeps signalling but nothing may be read.
        mon_clear();
        repeat (3 * P) @(negedge clk);
        @(posedge clk);
        check("idle sclk rises", m_rises_all, 0);
        check("idle cs low", m_low, 0);
        check("idle write_done", m_wd, 0);

        // Reset in the middle of a serial read.
        do_start(3'd0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 4 * P; i++) begin
            @(negedge clk);
            if (SCLK1 === 1'b1) begin found = 1'b1; break; end
        end
        check("shift reached", found, 1'b1);
        repeat (5) @(negedge clk);
        check("shift nCS1 low", nCS1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort nCS1", nCS1, 1'b1);
        check("abort SCLK1", SCLK1, 1'b0);
        reset = 1'b0;
        mon_clear();
        repeat (2 * P) @(negedge clk);
        @(posedge clk);
        check("after abort idle", m_rises_all, 0);

        // rate=0, counter data: full buffer, one write_done, then idle.
        mon_clear();
        do_start(3'd0, 1'b0);
`ifdef ADC_BUFF_TOGGLE_EN
        tog0 = toggle_buff;
`else
        tog0 = 1'b0;
`endif
        found = 1'b0;
        for (int i = 0; i < NS * P + 3 * P; i++) begin
            @(negedge clk);
            if ((i % 97) == 0) rate = 3'($urandom);
            if (write_done === 1'b1) begin found = 1'b1; break; end
        end
        check("rate0 write_done seen", found, 1'b1);
`ifdef ADC_BUFF_TOGGLE_EN
        @(negedge clk);
        check("rate0 toggle flip", toggle_buff, ~tog0);
`else
        repeat (3 * P) @(negedge clk);
        bus_checks("rate0", NS);
        check("rate0 wd pulses", m_wd, 1);
        check("rate0 wd width", m_wdwide, 0);
        check("rate0 tog unused", tog0, 1'b0);
`endif
        for (a = 0; a < 256; a++) begin
            read_byte(a, d);
            check($sformatf("rate0 byte %0d", a), d, exp_byte(a, 0, mark));
        end
        read_byte(3, d);   check("rate0 byte3 literal", d, 8'h01);
        read_byte(254, d); check("rate0 byte254 literal", d, 8'h00);
        read_byte(255, d); check("rate0 byte255 literal", d, 8'h7F);
        @(negedge clk);
        read_addr = 8'd2;
        #1;
        check("read latency hold", dout, 8'h7F);
        @(negedge clk);
        check("read latency update", dout, 8'h00);

        // rate=3, random data: only every 8th conversion is read.
        mon_clear();
        do_start(3'd3, 1'b1);
        repeat (1800) @(negedge clk);
        @(posedge clk);
        check("rate3 reads", m_reads, 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (a = 0; a < 4; a++) begin
            read_byte(a, d);
            check($sformatf("rate3 byte %0d", a), d, exp_byte(a, 3, mark));
        end

        // rate=1, random data, random rate input changes and a stray start.
        mon_clear();
        do_start(3'd1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 2 * NS * P + 3 * P; i++) begin
            @(negedge clk);
            if ((i % 53) == 0) rate = 3'($urandom);
            start_pulse = (i == 5000);
            if (write_done === 1'b1) begin found = 1'b1; break; end
        end
        start_pulse = 1'b0;
        check("rate1 write_done seen", found, 1'b1);
`ifndef ADC_BUFF_TOGGLE_EN
        repeat (2 * P) @(negedge clk);
        bus_checks("rate1", NS);
        check("rate1 wd pulses", m_wd, 1);
`endif
        for (int k = 0; k < 64; k++) begin
            a = int'($urandom_range(0, 255));
            read_byte(a, d);
            check($sformatf("rate1 byte %0d", a), d, exp_byte(a, 1, mark));
        end
        read_byte(254, d); check("rate1 byte254", d, exp_byte(254, 1, mark));
        read_byte(255, d); check("rate1 byte255", d, exp_byte(255, 1, mark));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
